// File: rtl/multimode_counter_pkg.sv
// Shared constants for the multimode ping-pong counter.
// Mode encodings and direction values.
package multimode_counter_pkg;

  typedef enum logic [1:0] {
    MODE_PINGPONG  = 2'd0,
    MODE_WRAP_UP   = 2'd1,
    MODE_WRAP_DOWN = 2'd2,
    MODE_ONESHOT   = 2'd3
  } mode_e;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler; strobes when all-ones and enabled.
// Synchronous clear restarts the advance period.
module tick_prescaler #(
  parameter int DIV_BITS = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic enable,
  output logic strobe
);

  logic [DIV_BITS-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (clr)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign strobe = enable & (&r_cnt);

endmodule

// File: rtl/multimode_ping_pong_counter.sv
// Bounded up/down counter with ping-pong, wrap and one-shot modes,
// advancing on prescaler strobes.
module multimode_ping_pong_counter
  import multimode_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DIV_BITS = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             flip,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] step,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             direction,
  output logic             adv,
  output logic             bounce,
  output logic             done,
  output logic             range_err
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_dir;
  logic             r_done;
  logic             r_bounce;
  logic             r_adv;
  logic             r_init;

  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_dir_nxt;
  logic             w_done_nxt;
  logic             w_bounce_nxt;
  logic             w_adv_nxt;

  logic             w_strobe;
  mode_e            w_mode;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_lo;
  logic             w_over;
  logic             w_under;
  logic [WIDTH-1:0] w_up_sat;
  logic [WIDTH-1:0] w_dn_sat;
  logic             w_at_bnd;
  logic             w_d;
  logic             w_od;

  tick_prescaler #(
    .DIV_BITS(DIV_BITS)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clr   (load),
    .enable(enable),
    .strobe(w_strobe)
  );

  assign w_mode = mode_e'(mode);

  assign range_err = (min >= max) | (r_cnt < min) | (r_cnt > max);

  // One extra bit so bound comparisons never see a wrapped value
  assign w_sum    = {1'b0, r_cnt} + {1'b0, step};
  assign w_lo     = {1'b0, min} + {1'b0, step};
  assign w_over   = w_sum > {1'b0, max};
  assign w_under  = {1'b0, r_cnt} < w_lo;
  assign w_up_sat = w_over ? max : w_sum[WIDTH-1:0];
  assign w_dn_sat = w_under ? min : r_cnt - step;

  // A flip landing on the bound in the travel direction is dropped
  assign w_at_bnd = (r_dir == UP && r_cnt == max) |
                    (r_dir == DOWN && r_cnt == min);
  assign w_d      = w_at_bnd ? r_dir : r_dir ^ flip;
  assign w_od     = r_dir ^ flip;

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_dir_nxt    = r_dir;
    w_done_nxt   = r_done;
    w_bounce_nxt = 1'b0;
    w_adv_nxt    = 1'b0;
    if (r_init) begin
      w_cnt_nxt = min;
    end else if (load) begin
      w_cnt_nxt  = load_val;
      w_dir_nxt  = UP;
      w_done_nxt = 1'b0;
    end else if (!range_err) begin
      unique case (w_mode)
        MODE_PINGPONG: begin
          if (w_strobe) begin
            w_adv_nxt = 1'b1;
            if (w_d == UP && r_cnt == max) begin
              w_dir_nxt    = DOWN;
              w_cnt_nxt    = w_dn_sat;
              w_bounce_nxt = 1'b1;
            end else if (w_d == DOWN && r_cnt == min) begin
              w_dir_nxt    = UP;
              w_cnt_nxt    = w_up_sat;
              w_bounce_nxt = 1'b1;
            end else begin
              w_dir_nxt = w_d;
              w_cnt_nxt = w_d ? w_up_sat : w_dn_sat;
            end
          end else begin
            w_dir_nxt = r_dir ^ flip;
          end
        end
        MODE_WRAP_UP: begin
          w_dir_nxt = UP;
          if (w_strobe) begin
            w_adv_nxt    = 1'b1;
            w_bounce_nxt = w_over;
            w_cnt_nxt    = w_over ? min : w_sum[WIDTH-1:0];
          end
        end
        MODE_WRAP_DOWN: begin
          w_dir_nxt = DOWN;
          if (w_strobe) begin
            w_adv_nxt    = 1'b1;
            w_bounce_nxt = w_under;
            w_cnt_nxt    = w_under ? max : r_cnt - step;
          end
        end
        MODE_ONESHOT: begin
          if (r_done) begin
            if (flip) begin
              w_done_nxt = 1'b0;
              w_dir_nxt  = ~r_dir;
            end
          end else begin
            w_dir_nxt = w_od;
            if (w_strobe) begin
              w_adv_nxt  = 1'b1;
              w_cnt_nxt  = w_od ? w_up_sat : w_dn_sat;
              w_done_nxt = w_od ? (w_up_sat == max) : (w_dn_sat == min);
            end
          end
        end
      endcase
    end
    if (w_mode != MODE_ONESHOT)
      w_done_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_dir    <= UP;
      r_done   <= 1'b0;
      r_bounce <= 1'b0;
      r_adv    <= 1'b0;
      r_init   <= 1'b1;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_dir    <= w_dir_nxt;
      r_done   <= w_done_nxt;
      r_bounce <= w_bounce_nxt;
      r_adv    <= w_adv_nxt;
      r_init   <= 1'b0;
    end
  end

  assign count     = r_cnt;
  assign direction = r_dir;
  assign adv       = r_adv;
  assign bounce    = r_bounce;
  assign done      = r_done;

endmodule

// File: tb/tb_multimode_ping_pong_counter.sv
// Randomised and directed bench for multimode_ping_pong_counter,
// checked every cycle against an integer reference model.
module tb_multimode_ping_pong_counter;

  localparam int W   = 4;
  localparam int D   = 2;
  localparam int TOP = (1 << D) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic         flip = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] b_max = '0;
  logic [W-1:0] b_min = '0;
  logic [W-1:0] b_step = '0;
  logic [1:0]   mode = 2'd0;
  logic [W-1:0] count;
  logic         direction;
  logic         adv;
  logic         bounce;
  logic         done;
  logic         range_err;

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt, m_pre;
  bit m_dir, m_done, m_b, m_a, m_init;

  multimode_ping_pong_counter #(
    .WIDTH(W),
    .DIV_BITS(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .flip     (flip),
    .load     (load),
    .load_val (load_val),
    .max      (b_max),
    .min      (b_min),
    .step     (b_step),
    .mode     (mode),
    .count    (count),
    .direction(direction),
    .adv      (adv),
    .bounce   (bounce),
    .done     (done),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int lim(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic bit m_re();
    return (b_min >= b_max) || (m_cnt < b_min) || (m_cnt > b_max);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_dir = 1; m_done = 0;
    m_b = 0; m_a = 0; m_pre = 0; m_init = 1;
  endtask

  task automatic model_edge();
    int mn, mx, st;
    bit stb, d, re;
    mn  = b_min;
    mx  = b_max;
    st  = b_step;
    re  = m_re();
    stb = enable && (m_pre == TOP);
    m_b = 0;
    m_a = 0;
    if (m_init) begin
      m_cnt  = mn;
      m_init = 0;
    end else if (load) begin
      m_cnt = load_val; m_dir = 1; m_done = 0;
    end else if (!re) begin
      case (mode)
        2'd0: begin
          if (!stb) m_dir = m_dir ^ flip;
          else begin
            m_a = 1;
            if ((m_dir && m_cnt == mx) || (!m_dir && m_cnt == mn)) d = m_dir;
            else d = m_dir ^ flip;
            if (d && m_cnt == mx) begin
              m_dir = 0; m_b = 1; m_cnt = lim(m_cnt - st, mn, mx);
            end else if (!d && m_cnt == mn) begin
              m_dir = 1; m_b = 1; m_cnt = lim(m_cnt + st, mn, mx);
            end else begin
              m_dir = d;
              m_cnt = lim(d ? m_cnt + st : m_cnt - st, mn, mx);
            end
          end
        end
        2'd1: begin
          m_dir = 1;
          if (stb) begin
            m_a = 1;
            if (m_cnt + st > mx) begin m_cnt = mn; m_b = 1; end
            else m_cnt = m_cnt + st;
          end
        end
        2'd2: begin
          m_dir = 0;
          if (stb) begin
            m_a = 1;
            if (m_cnt < mn + st) begin m_cnt = mx; m_b = 1; end
            else m_cnt = m_cnt - st;
          end
        end
        default: begin
          if (m_done) begin
            if (flip) begin m_done = 0; m_dir = !m_dir; end
          end else begin
            m_dir = m_dir ^ flip;
            if (stb) begin
              m_a = 1;
              m_cnt  = lim(m_dir ? m_cnt + st : m_cnt - st, mn, mx);
              m_done = (m_cnt == (m_dir ? mx : mn));
            end
          end
        end
      endcase
    end
    if (mode != 2'd3) m_done = 0;
    m_pre = load ? 0 : (m_pre + 1) % (TOP + 1);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check("count", count, m_cnt);
    check("direction", direction, m_dir);
    check("adv", adv, m_a);
    check("bounce", bounce, m_b);
    check("done", done, m_done);
    check("range_err", range_err, m_re());
    flip = 0;
    load = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_dir", direction, 1);
    check("rst_adv", adv, 0);
    rst = 0;
    cyc();
  endtask

  task automatic wait_adv(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!adv && n < 40);
    if (!adv) check("adv_timeout", 0, 1);
  endtask

  int exp1[7] = '{3, 4, 5, 4, 3, 2, 3};
  int bnc1[7] = '{0, 0, 0, 1, 0, 0, 1};
  int exp2[7] = '{4, 8, 9, 5, 1, 0, 4};
  int dir2[7] = '{1, 1, 1, 0, 0, 0, 1};

  initial begin
    int n, c0;

    // 1: ping-pong 2..5 step 1
    b_min = 2; b_max = 5; b_step = 1; mode = 2'd0;
    do_reset();
    check("t1_init", count, 2);
    for (int k = 0; k < 7; k++) begin
      wait_adv(n);
      check($sformatf("t1_cnt%0d", k), count, exp1[k]);
      check($sformatf("t1_bnc%0d", k), bounce, bnc1[k]);
    end

    // 2: ping-pong 0..9 step 4
    b_min = 0; b_max = 9; b_step = 4;
    do_reset();
    check("t2_init", count, 0);
    for (int k = 0; k < 7; k++) begin
      wait_adv(n);
      check($sformatf("t2_cnt%0d", k), count, exp2[k]);
      check($sformatf("t2_dir%0d", k), direction, dir2[k]);
    end

    // 3: wrap-up 3..12 step 5, flips ignored
    b_min = 3; b_max = 12; b_step = 5; mode = 2'd1;
    do_reset();
    flip = 1;
    cyc();
    check("t3_dir", direction, 1);
    wait_adv(n);
    check("t3_cnt0", count, 8);
    flip = 1;
    cyc();
    check("t3_dir2", direction, 1);
    wait_adv(n);
    check("t3_cnt1", count, 3);
    check("t3_bnc", bounce, 1);

    // 4: flip without advance, then flip on bound
    b_min = 0; b_max = 9; b_step = 1; mode = 2'd0;
    load_val = 6; load = 1;
    cyc();
    flip = 1;
    cyc();
    check("t4_dir", direction, 0);
    check("t4_cnt", count, 6);
    wait_adv(n);
    check("t4_next", count, 5);
    load_val = 9; load = 1;
    cyc();
    cyc(); cyc(); cyc();
    flip = 1;
    cyc();
    check("t4_adv", adv, 1);
    check("t4_bcnt", count, 8);
    check("t4_bdir", direction, 0);
    check("t4_bbnc", bounce, 1);

    // 5: one-shot up 1..7 step 3
    b_min = 1; b_max = 7; b_step = 3; mode = 2'd3;
    do_reset();
    wait_adv(n);
    check("t5_cnt0", count, 4);
    wait_adv(n);
    check("t5_cnt1", count, 7);
    check("t5_done", done, 1);
    repeat (10) cyc();
    check("t5_hold", count, 7);
    flip = 1;
    cyc();
    check("t5_undone", done, 0);
    check("t5_dir", direction, 0);
    wait_adv(n);
    check("t5_back", count, 4);

    // 6: range error hold, load recovery, async reset
    c0 = count;
    b_min = 8; b_max = 3; mode = 2'd0;
    cyc();
    check("t6_err", range_err, 1);
    for (int k = 0; k < 10; k++) begin
      flip = k[0];
      cyc();
    end
    check("t6_hold", count, c0);
    check("t6_hdir", direction, 0);
    b_min = 2; b_max = 9; load_val = 5; load = 1;
    cyc();
    check("t6_load", count, 5);
    check("t6_ok", range_err, 0);
    wait_adv(n);
    check("t6_restart", n, 4);
    #2 rst = 1;
    #1;
    check("t6_arst_cnt", count, 0);
    check("t6_arst_adv", adv, 0);
    check("t6_arst_dir", direction, 1);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    cyc();

    // random soak
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        mode   = 2'($urandom_range(0, 3));
        b_min  = W'($urandom_range(0, 7));
        b_max  = W'($urandom_range(0, 15));
        b_step = W'($urandom_range(0, 6));
      end
      enable   = ($urandom_range(0, 7) != 0);
      flip     = ($urandom_range(0, 4) == 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = W'($urandom_range(0, 15));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multimode_ping_pong_counter.md
Name: multimode_ping_pong_counter

Overview:
Parametrised next-generation ping-pong counter core. Counts between run-time bounds min and max with a programmable step, and supports four modes: ping-pong, wrap-up, wrap-down and one-shot. Advances are paced by an internal clock prescaler. Sits between the debounce/one_pulse front end, which supplies flip and load as 1-cycle pulses, and the seven-segment display driver, which consumes count and direction.

Parameters:
WIDTH, 4, bit width of count, bounds, step and load value
DIV_BITS, 27, prescaler width; one advance strobe every 2^DIV_BITS clk cycles
(Mode encodings are constants in the package, not parameters.)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  advance gate; 0 freezes count, prescaler keeps running
flip  in  1  1-cycle pulse; reverse direction
load  in  1  1-cycle pulse; load count from load_val
load_val  in  WIDTH  value written on load
max  in  WIDTH  upper bound (inclusive)
min  in  WIDTH  lower bound (inclusive)
step  in  WIDTH  increment per advance
mode  in  2  00 PINGPONG, 01 WRAP_UP, 10 WRAP_DOWN, 11 ONESHOT
count  out  WIDTH  current value
direction  out  1  1 = up, 0 = down
adv  out  1  1-cycle pulse, high on the cycle an advance is applied
bounce  out  1  1-cycle pulse on reversal at a bound or on wrap
done  out  1  ONESHOT only: count reached its target bound
range_err  out  1  level; combinational from the registered count and the bound inputs

Behaviour:
- Reset (async): count=0, direction=1, bounce=0, done=0, adv=0, prescaler=0, init_pending=1.
- First clk edge after reset release: count<=min, init_pending<=0. No advance occurs on this edge.
- Priority, highest first: rst > init_pending > load > range_err hold > advance/flip.
- load: count<=load_val, direction<=1, done<=0, prescaler<=0. Concurrent flip and advance are ignored.
- range_err = (min>max) | (min==max) | (count<min) | (count>max).
  - While range_err=1: count and direction hold; flip is ignored; adv=0.
- Prescaler: free-running DIV_BITS counter, cleared by rst and load. Advance strobe when it is all-ones and enable=1. adv mirrors the applied strobe.
- Arithmetic: sums and differences use WIDTH+1 bits, so there is no silent wrap. step==0 means count holds, but flip still acts.
- PINGPONG, on advance. Let d = direction after any same-cycle flip.
  - d=1 and count==max: direction<=0, count<=max(count-step, min), bounce=1. A flip in that cycle is ignored.
  - d=1 otherwise: count<=min(count+step, max).
  - d=0 is symmetric at min (reverse to up, count<=min(count+step, max), bounce=1).
  - Flip without advance: direction<=~direction, count unchanged.
- WRAP_UP: direction forced to 1; flip ignored. If count+step>max, count<=min and bounce=1; else count+=step.
- WRAP_DOWN: direction forced to 0; flip ignored. If count<min+step, count<=max and bounce=1; else count-=step.
- ONESHOT:
  - Moves per direction, saturating at max (up) or min (down).
  - On reaching the bound, done<=1 and further advances are ignored.
  - Flip while done=1 clears done and reverses direction.
  - Flip while done=0 reverses direction.
- Mode change mid-run takes effect on the next edge. done clears whenever mode != ONESHOT.
- bounce and adv are registered; each is high for exactly 1 cycle per event.

Decomposition:
- Package multimode_counter_pkg: mode encodings (MODE_PINGPONG=0, MODE_WRAP_UP=1, MODE_WRAP_DOWN=2, MODE_ONESHOT=3) and the UP/DOWN direction constants.
- Sub-module tick_prescaler(clk, rst, clr, enable, strobe): DIV_BITS counter with a synchronous clear.

Test Plan:
(All with WIDTH=4, DIV_BITS=2, i.e. one advance every 4 cycles, unless stated otherwise.)
1. Reset, min=2, max=5, step=1, PINGPONG -> count 0 during reset, 2 one edge after release. Over successive advances count runs 3,4,5,4,3,2,3; bounce pulses at 5→4 and 2→3.
2. PINGPONG, min=0, max=9, step=4 -> count 0,4,8,9,5,1,0,4. At 9: direction=0, count 5, bounce=1. At 0: direction=1.
3. WRAP_UP, min=3, max=12, step=5, count=3 -> 8, then 3 (13>12, bounce=1). Flip pulses cause no direction change.
4. Flip at count=6 going up, no advance that cycle (min=0, max=9) -> direction=0, count stays 6. Next advance gives 5. Flip coincident with an advance at count==max is ignored and the bound rule applies.
5. ONESHOT up, min=1, max=7, step=3, from 1 -> 4, 7, done=1, then holds 7 on later advances. Flip -> done=0, direction=0, next advance gives 4.
6. Range error: min=8, max=3 -> range_err=1; count and direction hold through advances and flips. Then load load_val=5 with min=2, max=9 -> count=5, range_err=0, prescaler restarts (next adv 4 cycles later). Assert rst mid-run -> outputs clear immediately, without waiting for a clk edge.
